vga_sync_rx: RTL and testbench
==============================

// Module: vga_sync_rx
// PURPOSE
//  Receive end of the VGA timing interface. Consumes hs/vs from a VGA timing source on the same pixel clock.
//  Measures line and frame totals, locks onto a stable raster and regenerates draw/x/y for downstream capture or checking.
//  Sits opposite the vga timing generator.
// PARAMETERS
//  H_ACTIVE    640  visible pixels per line
//  H_BP        48   pixels from hs trailing edge to first visible pixel
//  V_ACTIVE    480  visible lines per frame
//  V_BP        33   lines from vs trailing edge to first visible line
//  HS_POL      0    hs active level (0 = active-low)
//  VS_POL      0    vs active level (0 = active-low)
//  LOCK_FRAMES 2    consecutive matching frames required to lock (1..15)
// PORTS
//  clk      in   1   pixel clock; hs/vs are synchronous to it
//  rst      in   1   asynchronous reset, active-low
//  hs       in   1   horizontal sync
//  vs       in   1   vertical sync
//  draw     out  1   visible pixel, only while locked
//  x        out  10  column, 0..H_ACTIVE-1 while draw, else 0
//  y        out  9   row, 0..V_ACTIVE-1 while draw, else 0
//  locked   out  1   raster stable
//  h_total  out  12  last measured clocks per line
//  v_total  out  11  last measured lines per frame
// BEHAVIOUR
//  - Reset:
//    - All outputs and counters are 0; FSM is in SEARCH.
//  - Edge detection:
//    - hs/vs are registered once (hs_q/vs_q).
//    - hs trailing edge (HTE): hs_q active and hs inactive.
//    - vs trailing edge (VTE): same rule applied to vs.
//  - h_cnt (12b):
//    - On HTE, loads 0.
//    - Otherwise increments, saturating at 4095.
//    - On HTE, h_total <= h_cnt+1.
//  - v_cnt (11b):
//    - VTE sets frame_pend.
//    - At the next HTE: v_cnt <= 0, v_total <= v_cnt+1, frame_pend cleared. This is the frame boundary (FB).
//    - Any other HTE increments v_cnt, saturating at 2047.
//    - HTE and VTE on the same cycle: the HTE counts as the frame's last line; FB happens at the following HTE.
//  - FSM:
//    - SEARCH: wait for the first FB, then go to ACQUIRE with match_cnt=0.
//    - ACQUIRE: at each FB, the frame matches if every line had h_total equal to the first line's value and v_total equals the previous frame's value.
//      - Match: match_cnt++.
//      - Mismatch: match_cnt=0.
//      - When match_cnt reaches LOCK_FRAMES-1, enter LOCKED at that FB.
//    - LOCKED: any HTE with h_cnt+1 != locked h_total, or any FB with v_total != locked value, goes to ACQUIRE with match_cnt=0.
//    - Any state: h_cnt reaching 4095 (no hs) goes to SEARCH.
//  - locked is high exactly in LOCKED. It is registered and changes on the FB/HTE cycle that moves the FSM.
//  - draw/x/y are registered:
//    - draw=1 when locked, H_BP<=h_cnt<H_BP+H_ACTIVE and V_BP<=v_cnt<V_BP+V_ACTIVE.
//    - x = h_cnt-H_BP, y = v_cnt-V_BP.
//    - Latency: one clk after the counter value.
//    - draw drops the same cycle locked drops.
//  - Reset asserted mid-frame clears everything immediately. After release, lock needs a full re-acquire.
// CONFIGURATION
//  - VGA_RX_STATS_EN defined: adds ports frame_cnt out 16 and err_cnt out 16.
//    - frame_cnt increments at every FB.
//    - err_cnt increments on each LOCKED->ACQUIRE or ->SEARCH transition.
//    - Both saturate at 16'hFFFF and reset to 0.
//  - Not defined: ports and counters absent; all other behaviour identical.
// TESTING
//  - Reset: rst=0 with random hs/vs -> draw=x=y=locked=h_total=v_total=0.
//  - Lock: 800-clk lines (96-clk active-low hs), 525-line frames (2-line vs) -> h_total=800, v_total=525, locked rises at the 3rd FB.
//  - Raster: once locked, first draw cycle -> x=0,y=0 at h_cnt=48,v_cnt=33 (+1 clk); last -> x=639,y=479; exactly 307200 draw cycles per frame.
//  - Line glitch: one line of 801 clks while locked -> locked=0 on that HTE, draw=0; relock after 2 clean FBs.
//  - hs loss: hold hs inactive 4096 clks -> FSM SEARCH, locked=0; resumes lock after 3 FBs.
//  - Stats (VGA_RX_STATS_EN): 5 clean frames then glitch -> frame_cnt counts every FB, err_cnt=1; mid-frame rst -> both 0.

Source files
------------

// File: rtl/vga_sync_rx.sv
// vga_sync_rx: receive side of a VGA timing link.
// Measures line/frame totals from hs/vs, locks onto a stable raster and
// regenerates draw/x/y. Define VGA_RX_STATS_EN to add frame_cnt/err_cnt.
// state_dbg exposes the lock FSM: 0 = SEARCH, 1 = ACQUIRE, 2 = LOCKED.
// There is no handshake on this block: hs/vs are sampled every clock and all
// outputs are valid every clock.
module vga_sync_rx #(
  parameter int H_ACTIVE    = 640,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_BP        = 33,
  parameter bit HS_POL      = 1'b0,
  parameter bit VS_POL      = 1'b0,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hs,
  input  logic        vs,
  output logic        draw,
  output logic [9:0]  x,
  output logic [8:0]  y,
  output logic        locked,
  output logic [11:0] h_total,
  output logic [10:0] v_total,
`ifdef VGA_RX_STATS_EN
  output logic [15:0] frame_cnt,
  output logic [15:0] err_cnt,
`endif
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {SEARCH = 2'd0, ACQUIRE = 2'd1, LOCKED = 2'd2} state_t;

  localparam logic [4:0]  LOCK_TGT = 5'(LOCK_FRAMES - 1);
  localparam logic [11:0] H_LO     = 12'(H_BP);
  localparam logic [11:0] H_HI     = 12'(H_BP + H_ACTIVE);
  localparam logic [10:0] V_LO     = 11'(V_BP);
  localparam logic [10:0] V_HI     = 11'(V_BP + V_ACTIVE);

  state_t      state, state_n;
  logic        hs_q, vs_q;
  logic [11:0] h_cnt, ref_h, lock_h, h_len, ref_now;
  logic [10:0] v_cnt, lock_v, v_len;
  logic        frame_pend, first_line, h_ok;
  logic [3:0]  match_cnt, match_n;
  logic [4:0]  match_inc;
  logic        hte, vte, fb, h_sat, frame_match, do_lock, draw_d;

  assign hte         = (hs_q == HS_POL) && (hs != HS_POL);
  assign vte         = (vs_q == VS_POL) && (vs != VS_POL);
  assign fb          = hte && frame_pend;
  assign h_sat       = (h_cnt == 12'hFFF);
  assign h_len       = h_cnt + 12'd1;
  assign v_len       = v_cnt + 11'd1;
  assign match_inc   = {1'b0, match_cnt} + 5'd1;
  // A frame matches when all its lines equal its first line and its line
  // count repeats the previous frame's (v_total still holds that value).
  assign frame_match = (first_line || (h_ok && (h_len == ref_h))) && (v_len == v_total);
  assign ref_now     = first_line ? h_len : ref_h;
  assign state_dbg   = state;

  // Register sync inputs; reset to the inactive level so release is not an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hs_q <= ~HS_POL;
      vs_q <= ~VS_POL;
    end else begin
      hs_q <= hs;
      vs_q <= vs;
    end
  end

  // Pixel/line counters and the measured totals.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt      <= '0;
      h_total    <= '0;
      v_cnt      <= '0;
      v_total    <= '0;
      frame_pend <= 1'b0;
    end else begin
      if (hte) begin
        h_cnt   <= '0;
        h_total <= h_len;
      end else if (!h_sat) begin
        h_cnt <= h_len;
      end
      if (fb) begin
        v_cnt   <= '0;
        v_total <= v_len;
      end else if (hte && (v_cnt != 11'h7FF)) begin
        v_cnt <= v_len;
      end
      // A vs edge coincident with an hs edge defers the boundary one line.
      if (vte) frame_pend <= 1'b1;
      else if (fb) frame_pend <= 1'b0;
    end
  end

  // Per-frame line-length consistency: remember the first line, flag any other.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      first_line <= 1'b0;
      h_ok       <= 1'b0;
      ref_h      <= '0;
    end else if (hte) begin
      if (fb) begin
        first_line <= 1'b1;
      end else if (first_line) begin
        ref_h      <= h_len;
        h_ok       <= 1'b1;
        first_line <= 1'b0;
      end else if (h_len != ref_h) begin
        h_ok <= 1'b0;
      end
    end
  end

  // Lock FSM next-state logic; loss of hs overrides everything.
  always_comb begin
    state_n = state;
    match_n = match_cnt;
    do_lock = 1'b0;
    case (state)
      SEARCH: begin
        if (fb) begin
          state_n = ACQUIRE;
          match_n = '0;
        end
      end
      ACQUIRE: begin
        if (fb) begin
          if (frame_match) begin
            match_n = match_inc[3:0];
            if (match_inc >= LOCK_TGT) begin
              state_n = LOCKED;
              do_lock = 1'b1;
            end
          end else begin
            match_n = '0;
          end
        end
      end
      LOCKED: begin
        if (hte && ((h_len != lock_h) || (fb && (v_len != lock_v)))) begin
          state_n = ACQUIRE;
          match_n = '0;
        end
      end
      default: begin
        state_n = SEARCH;
        match_n = '0;
      end
    endcase
    if (h_sat) begin
      state_n = SEARCH;
      match_n = '0;
    end
  end

  // Raster window uses the next state so draw falls together with locked.
  always_comb begin
    draw_d = (state_n == LOCKED) && (h_cnt >= H_LO) && (h_cnt < H_HI) &&
             (v_cnt >= V_LO) && (v_cnt < V_HI);
  end

  // FSM state register, locked raster reference and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= SEARCH;
      match_cnt <= '0;
      lock_h    <= '0;
      lock_v    <= '0;
      locked    <= 1'b0;
      draw      <= 1'b0;
      x         <= '0;
      y         <= '0;
    end else begin
      state     <= state_n;
      match_cnt <= match_n;
      if (do_lock) begin
        lock_h <= ref_now;
        lock_v <= v_len;
      end
      locked <= (state_n == LOCKED);
      draw   <= draw_d;
      x      <= draw_d ? 10'(h_cnt - H_LO) : '0;
      y      <= draw_d ? 9'(v_cnt - V_LO) : '0;
    end
  end

`ifdef VGA_RX_STATS_EN
  // Frame and lock-loss counters, both saturating.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      if (fb && (frame_cnt != 16'hFFFF)) frame_cnt <= frame_cnt + 16'd1;
      if ((state == LOCKED) && (state_n != LOCKED) && (err_cnt != 16'hFFFF))
        err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_sync_rx.sv
// tb_vga_sync_rx: drives a reduced raster (80-clk lines, 30-line frames)
// and checks vga_sync_rx against a line/frame-level reference model.
module tb_vga_sync_rx;
  localparam int HSW = 10, LINE = 80, NLINES = 30;
  localparam int HBP = 6, HA = 56, VBP = 4, VA = 20, LF = 2;
  localparam int M_SEARCH = 0, M_ACQ = 1, M_LOCK = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        hs = 1'b1, vs = 1'b1;
  logic        draw, locked;
  logic [9:0]  x;
  logic [8:0]  y;
  logic [11:0] h_total;
  logic [10:0] v_total;
  logic [1:0]  state_dbg;
`ifdef VGA_RX_STATS_EN
  logic [15:0] frame_cnt, err_cnt;
`endif

  vga_sync_rx #(.H_ACTIVE(HA), .H_BP(HBP), .V_ACTIVE(VA), .V_BP(VBP),
                .HS_POL(1'b0), .VS_POL(1'b0), .LOCK_FRAMES(LF)) dut (
    .clk(clk), .rst(rst), .hs(hs), .vs(vs), .draw(draw), .x(x), .y(y),
    .locked(locked), .h_total(h_total), .v_total(v_total),
`ifdef VGA_RX_STATS_EN
    .frame_cnt(frame_cnt), .err_cnt(err_cnt),
`endif
    .state_dbg(state_dbg));

  // clock / bookkeeping
  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int edge_no = 0;
  // reference model state
  int m_state, m_match, m_h, m_v, lk_h, lk_v, ref_len, n_lines, last_hte;
  int m_frames, m_err, exp_draw, exp_x, exp_y;
  bit h_same, first_ln, pend;
  logic prev_hs, prev_vs;
  // raster / lock observations
  int dcount, r_cnt, r_fx, r_fy, r_lx, r_ly, fx, fy, lx, ly, fb_seen, lock_fb;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      if (bad <= 40) $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = M_SEARCH; m_match = 0; m_h = 0; m_v = 0; lk_h = 0; lk_v = 0;
    ref_len = 0; n_lines = 0; last_hte = edge_no; m_frames = 0; m_err = 0;
    h_same = 1'b0; first_ln = 1'b1; pend = 1'b0; prev_hs = 1'b1; prev_vs = 1'b1;
    dcount = 0; fb_seen = 0; lock_fb = 0;
  endtask

  // Line/frame level reference: line length = edges between hs trailing edges.
  task automatic model_edge(input logic hs_v, input logic vs_v, output bit fb);
    int hc, vc, len, vt;
    bit hte, vte, was_lock, match;
    hc = edge_no - 1 - last_hte;
    if (hc > 4095) hc = 4095;
    vc = n_lines;
    hte = (prev_hs == 1'b0) && (hs_v == 1'b1);
    vte = (prev_vs == 1'b0) && (vs_v == 1'b1);
    was_lock = (m_state == M_LOCK);
    fb = 1'b0;
    if (hte) begin
      len = (hc + 1) % 4096;
      last_hte = edge_no;
      fb = pend;
      m_h = len;
      n_lines++;
      if (first_ln) begin ref_len = len; h_same = 1'b1; first_ln = 1'b0; end
      else if (len != ref_len) h_same = 1'b0;
      vt = n_lines;
      match = h_same && (vt == m_v);
      if (m_state == M_LOCK) begin
        if ((len != lk_h) || (fb && (vt != lk_v))) begin m_state = M_ACQ; m_match = 0; end
      end else if (fb) begin
        if (m_state == M_SEARCH) begin m_state = M_ACQ; m_match = 0; end
        else if (match) begin
          m_match++;
          if (m_match >= LF - 1) begin m_state = M_LOCK; lk_h = ref_len; lk_v = vt; end
        end else m_match = 0;
      end
      if (fb) begin
        m_v = vt; n_lines = 0; first_ln = 1'b1;
        if (m_frames < 65535) m_frames++;
      end
    end
    if (vte) pend = 1'b1;
    else if (fb) pend = 1'b0;
    if (hc == 4095) m_state = M_SEARCH;
    if (was_lock && (m_state != M_LOCK) && (m_err < 65535)) m_err++;
    exp_draw = ((m_state == M_LOCK) && (hc >= HBP) && (hc < HBP + HA) &&
                (vc >= VBP) && (vc < VBP + VA)) ? 1 : 0;
    exp_x = exp_draw ? hc - HBP : 0;
    exp_y = exp_draw ? vc - VBP : 0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_draw"}, draw, 0);
    chk({tag, "_x"}, x, 0);
    chk({tag, "_y"}, y, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_h_total"}, h_total, 0);
    chk({tag, "_v_total"}, v_total, 0);
    chk({tag, "_state"}, state_dbg, M_SEARCH);
`ifdef VGA_RX_STATS_EN
    chk({tag, "_frame_cnt"}, frame_cnt, 0);
    chk({tag, "_err_cnt"}, err_cnt, 0);
`endif
  endtask

  // driver: one clock per call, inputs changed at negedge, outputs read #1 after posedge
  task automatic step(input logic hs_v, input logic vs_v);
    bit fb;
    hs = hs_v; vs = vs_v;
    @(posedge clk); #1;
    edge_no++;
    if (!rst) begin
      check_zero("reset");
    end else begin
      model_edge(hs_v, vs_v, fb);
      prev_hs = hs_v; prev_vs = vs_v;
      chk("draw", draw, exp_draw);
      chk("x", x, exp_x);
      chk("y", y, exp_y);
      chk("locked", locked, (m_state == M_LOCK) ? 1 : 0);
      chk("h_total", h_total, m_h);
      chk("v_total", v_total, m_v);
`ifdef VGA_RX_STATS_EN
      chk("frame_cnt", frame_cnt, m_frames);
      chk("err_cnt", err_cnt, m_err);
`endif
      if (draw === 1'b1) begin
        if (dcount == 0) begin fx = x; fy = y; end
        lx = x; ly = y; dcount++;
      end
      if (fb) begin
        r_cnt = dcount; r_fx = fx; r_fy = fy; r_lx = lx; r_ly = ly; dcount = 0;
        fb_seen++;
        if ((locked === 1'b1) && (lock_fb == 0)) lock_fb = fb_seen;
      end
    end
    @(negedge clk);
  endtask

  task automatic send_line(input int len, input logic vs_v);
    for (int i = 0; i < len; i++) step((i < HSW) ? 1'b0 : 1'b1, vs_v);
  endtask

  // frame: vs active on the last two lines; optional long line; optional early stop
  task automatic send_frame(input int glitch_ln, input int stop_ln);
    for (int k = 0; k < NLINES; k++) begin
      send_line((k == glitch_ln) ? LINE + 1 : LINE, (k >= NLINES - 2) ? 1'b0 : 1'b1);
      if (k == stop_ln) return;
    end
  endtask

  task automatic reset_phase(input int n);
    rst = 1'b0;
    #1;
    check_zero("rst_async");
    for (int i = 0; i < n; i++) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    rst = 1'b1; hs = 1'b1; vs = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    for (int i = 0; i < 20; i++) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    rst = 1'b1; hs = 1'b1; vs = 1'b1;
    model_reset();

    // power-up lock: locked rises at the third frame boundary
    for (int f = 0; f < 5; f++) send_frame(-1, -1);
    chk("lock_fb_powerup", lock_fb, 3);
    chk("h_total_lock", h_total, LINE);
    chk("v_total_lock", v_total, NLINES);
    chk("raster_count", r_cnt, HA * VA);
    chk("raster_first_x", r_fx, 0);
    chk("raster_first_y", r_fy, 0);
    chk("raster_last_x", r_lx, HA - 1);
    chk("raster_last_y", r_ly, VA - 1);

    // one long line while locked
    send_frame(7, 8);
    chk("glitch_locked", locked, 0);
    chk("glitch_draw", draw, 0);
`ifdef VGA_RX_STATS_EN
    chk("glitch_err_cnt", err_cnt, 1);
    chk("glitch_frame_cnt", frame_cnt, 5);
`endif
    fb_seen = 0; lock_fb = 0;
    for (int k = 9; k < NLINES; k++) send_line(LINE, (k >= NLINES - 2) ? 1'b0 : 1'b1);
    for (int f = 0; f < 3; f++) send_frame(-1, -1);
    chk("lock_fb_glitch", lock_fb, 2);

    // hs loss mid-frame, then a fresh raster
    send_frame(-1, 10);
    for (int i = 0; i < 4200; i++) step(1'b1, 1'b1);
    chk("loss_locked", locked, 0);
    chk("loss_state", state_dbg, M_SEARCH);
    fb_seen = 0; lock_fb = 0;
    for (int f = 0; f < 4; f++) send_frame(-1, -1);
    chk("lock_fb_loss", lock_fb, 3);

    // reset mid-frame, then full re-acquire
    send_frame(-1, 12);
    reset_phase(8);
    for (int f = 0; f < 4; f++) send_frame(-1, -1);
    chk("lock_fb_rerst", lock_fb, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
